// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, ALU-op and control-word definitions shared by the pipelined control unit
package ctrl_pkg;
  localparam logic [6:0] OP_ALU_R = 7'b0110011;
  localparam logic [6:0] OP_ALU_I = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_MUL = 2'b11;
  typedef struct packed {
    logic [1:0] alu_op;
    logic alu_src;
    logic branch;
    logic jump;
    logic mem_read;
    logic mem_write;
    logic mem_2_reg;
    logic reg_write;
    logic illegal;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/funct7 to control-word decoder; invalid slots decode as bubbles
module ctrl_decode import ctrl_pkg::*; (
  input  logic       instr_valid_i,
  input  logic [6:0] opcode_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o
);
  always_comb begin
    ctrl_o = CTRL_BUBBLE;
    if (instr_valid_i)
      case (opcode_i)
        OP_ALU_R: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op = funct7_i == FUNCT7_MULDIV ? ALU_OP_MUL : ALU_OP_FUNCT;
        end
        OP_ALU_I: begin
          ctrl_o.alu_src = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op = ALU_OP_FUNCT;
        end
        OP_LOAD: begin
          ctrl_o.alu_src = 1'b1;
          ctrl_o.mem_read = 1'b1;
          ctrl_o.mem_2_reg = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op = ALU_OP_ADD;
        end
        OP_STORE: begin
          ctrl_o.alu_src = 1'b1;
          ctrl_o.mem_write = 1'b1;
          ctrl_o.alu_op = ALU_OP_ADD;
        end
        OP_BRANCH: begin
          ctrl_o.branch = 1'b1;
          ctrl_o.alu_op = ALU_OP_SUB;
        end
        OP_JAL: begin
          ctrl_o.jump = 1'b1;
          ctrl_o.reg_write = 1'b1;
        end
        default: ctrl_o.illegal = 1'b1;
      endcase
  end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: ID decode, control pipeline to WB, multi-cycle MUL stall and flush.
// Defining CTRL_LOAD_USE_EN adds a load-use interlock on rs1/rs2.
module pipelined_control_unit import ctrl_pkg::*; #(
  parameter int MUL_LATENCY = 3,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [6:0]      opcode,
  input  logic [6:0]      funct7,
  input  logic [RD_W-1:0] rs1,
  input  logic [RD_W-1:0] rs2,
  input  logic [RD_W-1:0] rd,
  input  logic            flush,
  output logic            id_stall,
  output logic [1:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_illegal,
  output logic [RD_W-1:0] ex_rd,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic [RD_W-1:0] mem_rd,
  output logic            wb_reg_write,
  output logic            wb_mem_2_reg,
  output logic [RD_W-1:0] wb_rd
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int CW = $clog2(MUL_LATENCY + 1);
  localparam logic MULTI = MUL_LATENCY > 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ctrl_t id_ctrl, ex_q, ex_d;
  logic [RD_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q, wb_rd_q;
  logic mem_read_q, mem_write_q, mem_reg_write_q, mem_m2r_q;
  logic wb_reg_write_q, wb_m2r_q;
  logic busy, adv, start, lu;
  ctrl_decode u_dec (
    .instr_valid_i(instr_valid),
    .opcode_i(opcode),
    .funct7_i(funct7),
    .ctrl_o(id_ctrl)
  );
`ifdef CTRL_LOAD_USE_EN
  logic rs2_used;
  assign rs2_used = opcode inside {OP_ALU_R, OP_STORE, OP_BRANCH};
  assign lu = instr_valid & ~flush & ex_q.mem_read & (ex_rd_q != '0) &
              ((ex_rd_q == rs1) | (rs2_used & (ex_rd_q == rs2)));
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign lu = 1'b0;
`endif
  assign busy = state_q == BUSY;
  assign adv = ~flush & ~busy;
  assign start = adv & ~lu & MULTI & (id_ctrl.alu_op == ALU_OP_MUL);
  assign id_stall = ~flush & (busy | lu);
  // A busy MUL holds EX; load-use inserts a bubble while ID retries
  always_comb begin
    ex_d = flush ? CTRL_BUBBLE : busy ? ex_q : lu ? CTRL_BUBBLE : id_ctrl;
    ex_rd_d = flush ? '0 : busy ? ex_rd_q : (lu | ~instr_valid) ? '0 : rd;
    state_d = flush ? IDLE : busy ? (cnt_q == CW'(1) ? IDLE : BUSY) : start ? BUSY : IDLE;
    cnt_d = flush ? '0 : busy ? cnt_q - 1'b1 : start ? CW'(MUL_LATENCY - 1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ex_q <= CTRL_BUBBLE;
      ex_rd_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_m2r_q <= 1'b0;
      mem_rd_q <= '0;
      wb_reg_write_q <= 1'b0;
      wb_m2r_q <= 1'b0;
      wb_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ex_q <= ex_d;
      ex_rd_q <= ex_rd_d;
      mem_read_q <= adv & ex_q.mem_read;
      mem_write_q <= adv & ex_q.mem_write;
      mem_reg_write_q <= adv & ex_q.reg_write;
      mem_m2r_q <= adv & ex_q.mem_2_reg;
      mem_rd_q <= adv ? ex_rd_q : '0;
      wb_reg_write_q <= mem_reg_write_q;
      wb_m2r_q <= mem_m2r_q;
      wb_rd_q <= mem_rd_q;
    end
  end
  assign ex_alu_op = ex_q.alu_op;
  assign ex_alu_src = ex_q.alu_src;
  assign ex_branch = ex_q.branch;
  assign ex_jump = ex_q.jump;
  assign ex_illegal = ex_q.illegal;
  assign ex_rd = ex_rd_q;
  assign mem_mem_read = mem_read_q;
  assign mem_mem_write = mem_write_q;
  assign mem_rd = mem_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_mem_2_reg = wb_m2r_q;
  assign wb_rd = wb_rd_q;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed per-cycle vectors with a queued scoreboard and a negedge monitor
module tb_pipelined_control_unit;
  localparam logic [6:0] OR_ = 7'b0110011;
  localparam logic [6:0] OI = 7'b0010011;
  localparam logic [6:0] OL = 7'b0000011;
  localparam logic [6:0] OS = 7'b0100011;
  localparam logic [6:0] OB = 7'b1100011;
  localparam logic [6:0] OJ = 7'b1101111;
  localparam logic [6:0] OX = 7'b1111111;
  typedef struct {
    string n;
    logic [25:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst, instr_valid, flush;
  logic [6:0] opcode, funct7;
  logic [4:0] rs1, rs2, rd;
  logic id_stall, ex_alu_src, ex_branch, ex_jump, ex_illegal;
  logic mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_2_reg;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  exp_t sbq[$];
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  pipelined_control_unit #(.MUL_LATENCY(3), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .flush(flush), .id_stall(id_stall),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_illegal(ex_illegal), .ex_rd(ex_rd), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_rd(mem_rd), .wb_reg_write(wb_reg_write),
    .wb_mem_2_reg(wb_mem_2_reg), .wb_rd(wb_rd)
  );
  function automatic logic [31:0] enc(logic [6:0] op, logic [6:0] f7, logic [4:0] d, logic [4:0] s1, logic [4:0] s2);
    return {f7, s2, s1, 3'b000, d, op};
  endfunction
  // Inputs for one cycle plus the outputs expected while they are applied
  task automatic cyc(string n, logic r, logic v, logic [31:0] i, logic fl,
                     logic st, logic [1:0] aop, logic src, logic br, logic jp, logic il, logic [4:0] erd,
                     logic mr, logic mw, logic [4:0] mrd, logic wr, logic m2r, logic [4:0] wrd);
    @(posedge clk);
    #1;
    rst = r;
    instr_valid = v;
    opcode = i[6:0];
    funct7 = i[31:25];
    rd = i[11:7];
    rs1 = i[19:15];
    rs2 = i[24:20];
    flush = fl;
    sbq.push_back('{n, {st, aop, src, br, jp, il, erd, mr, mw, mrd, wr, m2r, wrd}});
  endtask
  initial begin : mon
    exp_t e;
    logic [25:0] a;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        a = {id_stall, ex_alu_op, ex_alu_src, ex_branch, ex_jump, ex_illegal, ex_rd,
             mem_mem_read, mem_mem_write, mem_rd, wb_reg_write, wb_mem_2_reg, wb_rd};
        compared++;
        if (a !== e.v) begin
          mismatched++;
          $display("FAIL %s: got %b expected %b", e.n, a, e.v);
        end
      end
    end
  end
  initial begin
    logic [31:0] lw7, add10, lw11, sw, beq, jal1, mul3, add4, mul5, add6a, lw5, add6, lw0, add7, ill, add9, lw10, nop;
    lw7 = enc(OL, 7'd0, 5'd7, 5'd1, 5'd0);
    add10 = enc(OR_, 7'd0, 5'd10, 5'd1, 5'd2);
    lw11 = enc(OL, 7'd0, 5'd11, 5'd2, 5'd0);
    sw = enc(OS, 7'd0, 5'd0, 5'd2, 5'd3);
    beq = enc(OB, 7'd0, 5'd0, 5'd4, 5'd5);
    jal1 = enc(OJ, 7'd0, 5'd1, 5'd0, 5'd0);
    mul3 = enc(OR_, 7'd1, 5'd3, 5'd1, 5'd2);
    add4 = enc(OR_, 7'd0, 5'd4, 5'd1, 5'd1);
    mul5 = enc(OR_, 7'd1, 5'd5, 5'd1, 5'd2);
    add6a = enc(OI, 7'd0, 5'd6, 5'd1, 5'd1);
    lw5 = enc(OL, 7'd0, 5'd5, 5'd1, 5'd0);
    add6 = enc(OR_, 7'd0, 5'd6, 5'd5, 5'd1);
    lw0 = enc(OL, 7'd0, 5'd0, 5'd1, 5'd0);
    add7 = enc(OR_, 7'd0, 5'd7, 5'd0, 5'd1);
    ill = enc(OX, 7'd0, 5'd8, 5'd0, 5'd0);
    add9 = enc(OR_, 7'd0, 5'd9, 5'd1, 5'd2);
    lw10 = enc(OL, 7'd0, 5'd10, 5'd2, 5'd0);
    nop = '0;
    rst = 1'b1; instr_valid = 1'b0; flush = 1'b0;
    opcode = '0; funct7 = '0; rs1 = '0; rs2 = '0; rd = '0;
    //     name          r  v  instr  fl  st aop   src br jp il erd   mr mw mrd   wr m2r wrd
    cyc("rst1",          1, 1, lw7,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("rst2",          1, 1, lw7,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("rst_drop",      0, 1, lw7,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("ex_lw",         0, 1, add10, 0,  0, 2'd0, 1, 0, 0, 0, 5'd7, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("ex_add",        0, 1, lw11,  0,  0, 2'd2, 0, 0, 0, 0, 5'd10,1, 0, 5'd7, 0, 0, 5'd0);
    cyc("ex_lw2",        0, 1, sw,    0,  0, 2'd0, 1, 0, 0, 0, 5'd11,0, 0, 5'd10,1, 1, 5'd7);
    cyc("ex_sw",         0, 1, beq,   0,  0, 2'd0, 1, 0, 0, 0, 5'd0, 1, 0, 5'd11,1, 0, 5'd10);
    cyc("ex_beq",        0, 1, jal1,  0,  0, 2'd1, 0, 1, 0, 0, 5'd0, 0, 1, 5'd0, 1, 1, 5'd11);
    cyc("ex_jal",        0, 0, nop,   0,  0, 2'd0, 0, 0, 1, 0, 5'd1, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("mem_jal",       0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd1, 0, 0, 5'd0);
    cyc("wb_jal",        0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 1, 0, 5'd1);
    cyc("id_mul",        0, 1, mul3,  0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("mul_busy1",     0, 1, add4,  0,  1, 2'd3, 0, 0, 0, 0, 5'd3, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("mul_busy2",     0, 1, add4,  0,  1, 2'd3, 0, 0, 0, 0, 5'd3, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("mul_last",      0, 1, add4,  0,  0, 2'd3, 0, 0, 0, 0, 5'd3, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("add_after_mul", 0, 0, nop,   0,  0, 2'd2, 0, 0, 0, 0, 5'd4, 0, 0, 5'd3, 0, 0, 5'd0);
    cyc("wb_mul",        0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd4, 1, 0, 5'd3);
    cyc("wb_add4",       0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 1, 0, 5'd4);
    cyc("id_mul5",       0, 1, mul5,  0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("mul5_busy1",    0, 1, add6a, 0,  1, 2'd3, 0, 0, 0, 0, 5'd5, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("mul5_flush",    0, 1, add6a, 1,  0, 2'd3, 0, 0, 0, 0, 5'd5, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("post_flush1",   0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("post_flush2",   0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("post_flush3",   0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("id_lw5",        0, 1, lw5,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
`ifdef CTRL_LOAD_USE_EN
    cyc("lu_stall",      0, 1, add6,  0,  1, 2'd0, 1, 0, 0, 0, 5'd5, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("lu_bubble",     0, 1, add6,  0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 1, 0, 5'd5, 0, 0, 5'd0);
    cyc("lu_ex_add",     0, 0, nop,   0,  0, 2'd2, 0, 0, 0, 0, 5'd6, 0, 0, 5'd0, 1, 1, 5'd5);
    cyc("lu_mem_add",    0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd6, 0, 0, 5'd0);
    cyc("lu_wb_add",     0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 1, 0, 5'd6);
`else
    cyc("lu_nostall",    0, 1, add6,  0,  0, 2'd0, 1, 0, 0, 0, 5'd5, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("lu_ex_add",     0, 0, nop,   0,  0, 2'd2, 0, 0, 0, 0, 5'd6, 1, 0, 5'd5, 0, 0, 5'd0);
    cyc("lu_mem_add",    0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd6, 1, 1, 5'd5);
    cyc("lu_wb_add",     0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 1, 0, 5'd6);
    cyc("lu_drain",      0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
`endif
    cyc("id_lw0",        0, 1, lw0,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("rd0_nostall",   0, 1, add7,  0,  0, 2'd0, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("id_illegal",    0, 1, ill,   0,  0, 2'd2, 0, 0, 0, 0, 5'd7, 1, 0, 5'd0, 0, 0, 5'd0);
    cyc("ex_illegal",    0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 1, 5'd8, 0, 0, 5'd7, 1, 1, 5'd0);
    cyc("ill_pulse_end", 0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd8, 1, 0, 5'd7);
    cyc("wb_illegal",    0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd8);
    cyc("idle",          0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("id_add9",       0, 1, add9,  0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("flush_ex_add",  0, 1, lw10,  1,  0, 2'd2, 0, 0, 0, 0, 5'd9, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("flush_killed",  0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    cyc("flush_drain",   0, 0, nop,   0,  0, 2'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0);
    for (int k = 0; k < 10 && sbq.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sbq.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
